rr_arbiter_4x1: RTL and testbench

RR_ARBITER_4X1 -- requirements
Module: rr_arbiter_4x1

---
 rtl/arb_pkg.sv | 32 +++
 rtl/mux_4x1.sv | 25 ++
 rtl/rr_arbiter_4x1.sv | 115 +++++++++++
 tb/tb_rr_arbiter_4x1.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the 4-way round-robin arbiter: FSM state, requester count, rotating pick.
// Pure package; no latency or backpressure of its own.
package arb_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       vld;
      logic [1:0] idx;
   } pick_t;

   // Walk from the highest offset down so the lowest offset from start wins.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] start);
      pick_t      p;
      logic [1:0] idx;
      p = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = start + 2'(i);
         if (req[idx]) begin
            p.vld = 1'b1;
            p.idx = idx;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_4x1.sv
// 4:1 payload mux, purely combinational (zero latency).
// No flow control; output follows sel and inputs directly.
module mux_4x1 #(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = in0;
      case (sel)
         2'd0: out = in0;
         2'd1: out = in1;
         2'd2: out = in2;
         2'd3: out = in3;
         default: out = in0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4x1.sv
// Round-robin 4:1 ownership arbiter with hold-limit preemption; grant visible 1 cycle after request.
// Requesters hold req while they want the port; an owner is preempted after MAX_HOLD cycles if others wait.
module rr_arbiter_4x1
   import arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [WIDTH-1:0]   in0,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic [WIDTH-1:0]   in3,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         sel,
   output logic               busy,
   output logic [WIDTH-1:0]   out
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   arb_state_e         state, state_nxt;
   logic [1:0]         ptr, ptr_nxt;
   logic [7:0]         hold_cnt, hold_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic [1:0]         sel_nxt;
   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] others;
   logic               arb;
   pick_t              pick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         hold_cnt <= 8'd0;
         gnt      <= '0;
         sel      <= 2'd0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         sel      <= sel_nxt;
      end
   end

   // gnt is zero in IDLE, so masking it out leaves every requester eligible there.
   assign others = req & ~gnt;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      cand      = '0;
      arb       = 1'b0;

      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (req != '0) begin
               arb  = 1'b1;
               cand = req;
            end
         end
         OWNED: begin
            if (!req[sel]) begin
               if (others != '0) begin
                  arb  = 1'b1;
                  cand = others;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end else if (hold_cnt == HOLD_LAST && others != '0) begin
               arb  = 1'b1;
               cand = others;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase

      pick = rr_pick(cand, ptr);
      if (arb && pick.vld) begin
         state_nxt = OWNED;
         sel_nxt   = pick.idx;
         gnt_nxt   = 4'b0001 << pick.idx;
         ptr_nxt   = pick.idx + 2'd1;
         hold_nxt  = 8'd0;
      end
   end

   assign busy = (state == OWNED);

   mux_4x1 #(
      .WIDTH(WIDTH)
   ) u_mux (
      .sel(sel),
      .in0(in0),
      .in1(in1),
      .in2(in2),
      .in3(in3),
      .out(out)
   );

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// Bench for rr_arbiter_4x1: default instance plus a MAX_HOLD=4 instance on shared inputs.
// Expected grant/sel/busy are queued as each stimulus cycle is driven and popped after the edge.
module tb_rr_arbiter_4x1;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [W-1:0] in0, in1, in2, in3;
   logic [3:0]   gnt_a, gnt_b;
   logic [1:0]   sel_a, sel_b;
   logic         busy_a, busy_b;
   logic [W-1:0] out_a, out_b;

   always #5 clk = ~clk;

   rr_arbiter_4x1 #(.WIDTH(W), .MAX_HOLD(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .out(out_a)
   );

   rr_arbiter_4x1 #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .out(out_b)
   );

   typedef struct {
      int         inst;
      string      tag;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] din(input logic [1:0] i);
      case (i)
         2'd0:    din = in0;
         2'd1:    din = in1;
         2'd2:    din = in2;
         default: din = in3;
      endcase
   endfunction

   task automatic step(input logic rs, input logic [3:0] r, input int inst,
                       input logic [3:0] eg, input logic [1:0] es, input logic eb,
                       input string tag);
      exp_t e;
      @(negedge clk);
      rst_n  = rs;
      req    = r;
      e.inst = inst;
      e.tag  = tag;
      e.gnt  = eg;
      e.sel  = es;
      e.busy = eb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.inst == 0) begin
         chk({e.tag, "/gnt"},  32'(gnt_a),  32'(e.gnt));
         chk({e.tag, "/sel"},  32'(sel_a),  32'(e.sel));
         chk({e.tag, "/busy"}, 32'(busy_a), 32'(e.busy));
         chk({e.tag, "/out"},  out_a,       din(e.sel));
      end else begin
         chk({e.tag, "/gnt"},  32'(gnt_b),  32'(e.gnt));
         chk({e.tag, "/sel"},  32'(sel_b),  32'(e.sel));
         chk({e.tag, "/busy"}, 32'(busy_b), 32'(e.busy));
         chk({e.tag, "/out"},  out_b,       din(e.sel));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] eg;
      logic [1:0] es;
      rst_n = 1'b0;
      req   = 4'b0000;
      in0   = 32'hA0A0_0000;
      in1   = 32'h1111_1111;
      in2   = 32'h2222_2222;
      in3   = 32'hDEAD_BEEF;

      step(1'b0, 4'b0000, 0, 4'b0000, 2'd0, 1'b0, "rst_a");
      step(1'b0, 4'b0000, 1, 4'b0000, 2'd0, 1'b0, "rst_b");

      // Two requesters; lower index wins from ptr=0, then release hands over with no gap.
      step(1'b1, 4'b0101, 0, 4'b0001, 2'd0, 1'b1, "own0");
      step(1'b1, 4'b0100, 0, 4'b0100, 2'd2, 1'b1, "rel0_to2");
      step(1'b1, 4'b1000, 0, 4'b1000, 2'd3, 1'b1, "swap2_3");
      chk("out_deadbeef", out_a, 32'hDEAD_BEEF);

      // Reset mid-ownership, then full contention restarts at index 0.
      step(1'b0, 4'b1000, 0, 4'b0000, 2'd0, 1'b0, "rst_mid");
      step(1'b1, 4'b1111, 0, 4'b0001, 2'd0, 1'b1, "post_rst");

      step(1'b1, 4'b0010, 0, 4'b0010, 2'd1, 1'b1, "rel0_to1");
      step(1'b1, 4'b0000, 0, 4'b0000, 2'd1, 1'b0, "all_drop");
      in1 = 32'h5A5A_1234;
      step(1'b1, 4'b0000, 0, 4'b0000, 2'd1, 1'b0, "idle_hold");
      step(1'b1, 4'b1111, 0, 4'b0100, 2'd2, 1'b1, "ptr_rr");

      // Sole requester: never preempted, hold counter saturates.
      step(1'b1, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, "own0_solo");
      for (int k = 0; k < 19; k++) begin
         in0 = $urandom;
         step(1'b1, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, "solo_hold");
      end
      chk("hold_sat", 32'(dut.hold_cnt), 32'd7);

      // MAX_HOLD=4 with two constant requesters alternates every 4 cycles.
      step(1'b0, 4'b0000, 1, 4'b0000, 2'd0, 1'b0, "rst_b2");
      for (int k = 0; k < 24; k++) begin
         es = ((k / 4) % 2 == 1) ? 2'd1 : 2'd0;
         eg = (es == 2'd1) ? 4'b0010 : 4'b0001;
         step(1'b1, 4'b0011, 1, eg, es, 1'b1, "alt");
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
